top_rst_seq: RTL and testbench
==============================

TOP_RST_SEQ -- requirements
Module: top_rst_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before the first release; legal range >= 2.
REQ-002 SHALL have parameter STAGE_GAP, default 16: cycles between successive domain releases; legal range >= 1.
REQ-003 SHALL have port CLK, input, 1 bit: single clock for all logic (FPGA_CLK1_50 domain).
REQ-004 SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port PLL_LOCKED, input, 1 bit: PLL lock status, asynchronous to CLK.
REQ-006 SHALL have port SW_RESET, input, 1 bit: synchronous request to re-run the reset sequence, sampled every cycle.
REQ-007 SHALL have port RST_SYS_N, output, 1 bit: active-low reset for the system domain, released first.
REQ-008 SHALL have port RST_CORE_N, output, 1 bit: active-low reset for the core domain, released second.
REQ-009 SHALL have port RST_VIDEO_N, output, 1 bit: active-low reset for the video domain, released last.
REQ-010 SHALL have port READY, output, 1 bit: high while all three domain resets are released.
REQ-011 SHALL have port LOCK_LOSS_CNT, output, 8 bits: saturating count of lock-loss events.

Function
REQ-012 SHALL synchronize PLL_LOCKED through two flops clocked by CLK (lk_s); all decisions use lk_s only, giving 2 cycles of input latency.
REQ-013 SHALL implement states WAIT_LOCK, REL_SYS, REL_CORE, RUN.
REQ-014 In WAIT_LOCK, SHALL increment the stable counter on each cycle with lk_s=1 and clear it to 0 on any cycle with lk_s=0.
REQ-015 SHALL transition WAIT_LOCK -> REL_SYS when the counter reaches LOCK_STABLE_CYCLES, clear the counter, and drive RST_SYS_N=1 from that edge.
REQ-016 In REL_SYS, after STAGE_GAP cycles, SHALL transition to REL_CORE and drive RST_CORE_N=1 from that edge.
REQ-017 In REL_CORE, after STAGE_GAP cycles, SHALL transition to RUN and drive RST_VIDEO_N=1 and READY=1 from that edge.
REQ-018 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-019 On lk_s=0 in REL_SYS, REL_CORE or RUN, SHALL on the next edge drive all RST_*_N=0 and READY=0, return to WAIT_LOCK, clear the counter, and increment LOCK_LOSS_CNT by 1.
REQ-020 LOCK_LOSS_CNT SHALL saturate at 255 and never wrap.
REQ-021 Lock loss in WAIT_LOCK SHALL only restart the counter and SHALL NOT increment LOCK_LOSS_CNT.
REQ-022 On SW_RESET=1 in any state, SHALL on the next edge assert all resets, drop READY, clear the counter, and go to WAIT_LOCK, without incrementing LOCK_LOSS_CNT.
REQ-023 On simultaneous SW_RESET=1 and lk_s=0 outside WAIT_LOCK, SHALL treat the event as a lock loss, incrementing LOCK_LOSS_CNT exactly once.
REQ-024 Resets SHALL release in strict order SYS, CORE, VIDEO and never release out of order; any reassertion SHALL assert all three in the same cycle.
REQ-025 Counter width SHALL be clog2(LOCK_STABLE_CYCLES+1) bits, sized so it cannot overflow before the comparison is reached.

Reset
REQ-026 While RESET_N=0, SHALL asynchronously force: state WAIT_LOCK, sync flops 0, counter 0, RST_SYS_N=0, RST_CORE_N=0, RST_VIDEO_N=0, READY=0, LOCK_LOSS_CNT=0.
REQ-027 Deassertion of RESET_N mid-sequence SHALL restart from WAIT_LOCK with no output glitch high.

Verification (LOCK_STABLE_CYCLES=8, STAGE_GAP=4)
REQ-028 Normal bring-up: PLL_LOCKED rises at cycle 0 and is held -> RST_SYS_N=1 at cycle 10, RST_CORE_N=1 at cycle 14, RST_VIDEO_N=1 and READY=1 at cycle 18.
REQ-029 Lock glitch: PLL_LOCKED high 5 cycles, low 1 cycle, then high -> no release until 8 consecutive lk_s-high cycles after the glitch; LOCK_LOSS_CNT stays 0.
REQ-030 Lock loss in RUN: drop PLL_LOCKED -> all resets=0 and READY=0 three cycles later; LOCK_LOSS_CNT=1; relock re-runs the full sequence.
REQ-031 SW_RESET and lock loss in the same cycle while in RUN -> single reassertion; LOCK_LOSS_CNT increments by exactly 1.
REQ-032 Saturation: 300 lock-loss events after release -> LOCK_LOSS_CNT=255.
REQ-033 RESET_N pulsed low during REL_CORE -> all outputs 0 immediately (asynchronously); sequence restarts from WAIT_LOCK.

Source files
------------

// File: rtl/top_rst_seq.sv
// Power-on reset sequencer: waits for a stable PLL lock, then releases the
// system, core and video domain resets in order, STAGE_GAP cycles apart.
module top_rst_seq #(
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned STAGE_GAP          = 16
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       PLL_LOCKED,
   input  logic       SW_RESET,
   output logic       RST_SYS_N,
   output logic       RST_CORE_N,
   output logic       RST_VIDEO_N,
   output logic       READY,
   output logic [7:0] LOCK_LOSS_CNT,
   output logic [1:0] dbg_state
);

   localparam int unsigned CW = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned GW = $clog2(STAGE_GAP + 1);

   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      REL_SYS   = 2'd1,
      REL_CORE  = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t        state;
   logic          sync1;
   logic          lk_s;
   logic [CW-1:0] stable_cnt;
   logic [GW-1:0] gap_cnt;

   assign dbg_state = state;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state         <= WAIT_LOCK;
         sync1         <= 1'b0;
         lk_s          <= 1'b0;
         stable_cnt    <= '0;
         gap_cnt       <= '0;
         RST_SYS_N     <= 1'b0;
         RST_CORE_N    <= 1'b0;
         RST_VIDEO_N   <= 1'b0;
         READY         <= 1'b0;
         LOCK_LOSS_CNT <= 8'd0;
      end else begin
         sync1 <= PLL_LOCKED;
         lk_s  <= sync1;

         // Lock loss outranks SW_RESET so a coincident pair is counted once.
         if ((state != WAIT_LOCK) && !lk_s) begin
            state       <= WAIT_LOCK;
            stable_cnt  <= '0;
            gap_cnt     <= '0;
            RST_SYS_N   <= 1'b0;
            RST_CORE_N  <= 1'b0;
            RST_VIDEO_N <= 1'b0;
            READY       <= 1'b0;
            if (LOCK_LOSS_CNT != 8'hFF) begin
               LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
            end
         end else if (SW_RESET) begin
            state       <= WAIT_LOCK;
            stable_cnt  <= '0;
            gap_cnt     <= '0;
            RST_SYS_N   <= 1'b0;
            RST_CORE_N  <= 1'b0;
            RST_VIDEO_N <= 1'b0;
            READY       <= 1'b0;
         end else begin
            case (state)
               WAIT_LOCK: begin
                  if (!lk_s) begin
                     stable_cnt <= '0;
                  end else if (stable_cnt == LOCK_LAST) begin
                     state      <= REL_SYS;
                     stable_cnt <= '0;
                     gap_cnt    <= '0;
                     RST_SYS_N  <= 1'b1;
                  end else begin
                     stable_cnt <= stable_cnt + 1'b1;
                  end
               end
               REL_SYS: begin
                  if (gap_cnt == GAP_LAST) begin
                     state      <= REL_CORE;
                     gap_cnt    <= '0;
                     RST_CORE_N <= 1'b1;
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
               REL_CORE: begin
                  if (gap_cnt == GAP_LAST) begin
                     state       <= RUN;
                     gap_cnt     <= '0;
                     RST_VIDEO_N <= 1'b1;
                     READY       <= 1'b1;
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
               RUN: begin
                  gap_cnt <= '0;
               end
               default: begin
                  state       <= WAIT_LOCK;
                  stable_cnt  <= '0;
                  gap_cnt     <= '0;
                  RST_SYS_N   <= 1'b0;
                  RST_CORE_N  <= 1'b0;
                  RST_VIDEO_N <= 1'b0;
                  READY       <= 1'b0;
               end
            endcase
         end
      end
   end

   // Release ordering invariants: a later domain never runs ahead of an earlier one.
   assert property (@(posedge CLK) disable iff (!RESET_N) RST_CORE_N |-> RST_SYS_N);
   assert property (@(posedge CLK) disable iff (!RESET_N) RST_VIDEO_N |-> RST_CORE_N);
   assert property (@(posedge CLK) disable iff (!RESET_N) READY == RST_VIDEO_N);

endmodule

// File: tb/tb_top_rst_seq.sv
// Directed bench for top_rst_seq with LOCK_STABLE_CYCLES=8, STAGE_GAP=4.
module tb_top_rst_seq;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic       PLL_LOCKED;
   logic       SW_RESET;
   logic       RST_SYS_N;
   logic       RST_CORE_N;
   logic       RST_VIDEO_N;
   logic       READY;
   logic [7:0] LOCK_LOSS_CNT;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   top_rst_seq #(
      .LOCK_STABLE_CYCLES(8),
      .STAGE_GAP(4)
   ) dut (
      .CLK(CLK),
      .RESET_N(RESET_N),
      .PLL_LOCKED(PLL_LOCKED),
      .SW_RESET(SW_RESET),
      .RST_SYS_N(RST_SYS_N),
      .RST_CORE_N(RST_CORE_N),
      .RST_VIDEO_N(RST_VIDEO_N),
      .READY(READY),
      .LOCK_LOSS_CNT(LOCK_LOSS_CNT),
      .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Expects PLL_LOCKED to have just gone high after the current edge, with lk_s low.
   task automatic bringup(input string tag);
      for (int i = 1; i <= 18; i++) begin
         step();
         if (i == 9)  check({tag, "_sys_early"}, 32'(RST_SYS_N), 0);
         if (i == 10) begin
            check({tag, "_sys_rel"}, 32'(RST_SYS_N), 1);
            check({tag, "_core_held"}, 32'(RST_CORE_N), 0);
         end
         if (i == 13) check({tag, "_core_early"}, 32'(RST_CORE_N), 0);
         if (i == 14) begin
            check({tag, "_core_rel"}, 32'(RST_CORE_N), 1);
            check({tag, "_video_held"}, 32'(RST_VIDEO_N), 0);
         end
         if (i == 17) begin
            check({tag, "_video_early"}, 32'(RST_VIDEO_N), 0);
            check({tag, "_ready_early"}, 32'(READY), 0);
         end
         if (i == 18) begin
            check({tag, "_video_rel"}, 32'(RST_VIDEO_N), 1);
            check({tag, "_ready_rel"}, 32'(READY), 1);
            check({tag, "_state_run"}, 32'(dbg_state), 3);
         end
      end
   endtask

   initial begin
      int t;
      RESET_N    = 1'b0;
      PLL_LOCKED = 1'b0;
      SW_RESET   = 1'b0;
      repeat (3) step();
      check("rst_sys", 32'(RST_SYS_N), 0);
      check("rst_core", 32'(RST_CORE_N), 0);
      check("rst_video", 32'(RST_VIDEO_N), 0);
      check("rst_ready", 32'(READY), 0);
      check("rst_cnt", 32'(LOCK_LOSS_CNT), 0);
      check("rst_state", 32'(dbg_state), 0);

      // Normal bring-up
      RESET_N    = 1'b1;
      PLL_LOCKED = 1'b1;
      bringup("boot");
      check("boot_cnt", 32'(LOCK_LOSS_CNT), 0);

      // Lock loss in RUN: outputs drop three edges after PLL_LOCKED falls
      step(); step();
      PLL_LOCKED = 1'b0;
      step(); check("loss_ready_e1", 32'(READY), 1);
      step(); check("loss_ready_e2", 32'(READY), 1);
      step();
      check("loss_sys", 32'(RST_SYS_N), 0);
      check("loss_core", 32'(RST_CORE_N), 0);
      check("loss_video", 32'(RST_VIDEO_N), 0);
      check("loss_ready", 32'(READY), 0);
      check("loss_cnt", 32'(LOCK_LOSS_CNT), 1);
      PLL_LOCKED = 1'b1;
      bringup("relock");

      // SW_RESET coinciding with lk_s low in RUN
      step(); step();
      PLL_LOCKED = 1'b0;
      step(); step();
      SW_RESET = 1'b1;
      step();
      SW_RESET = 1'b0;
      check("swloss_sys", 32'(RST_SYS_N), 0);
      check("swloss_ready", 32'(READY), 0);
      check("swloss_cnt", 32'(LOCK_LOSS_CNT), 2);
      PLL_LOCKED = 1'b1;
      bringup("swloss_relock");
      check("swloss_cnt_after", 32'(LOCK_LOSS_CNT), 2);

      // Plain SW_RESET in RUN with lock held: counter restarts from zero
      SW_RESET = 1'b1;
      step();
      SW_RESET = 1'b0;
      check("sw_sys", 32'(RST_SYS_N), 0);
      check("sw_video", 32'(RST_VIDEO_N), 0);
      check("sw_ready", 32'(READY), 0);
      check("sw_cnt", 32'(LOCK_LOSS_CNT), 2);
      check("sw_state", 32'(dbg_state), 0);
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 7) check("sw_sys_early", 32'(RST_SYS_N), 0);
         if (i == 8) check("sw_sys_rel", 32'(RST_SYS_N), 1);
      end

      // Lock glitch after a fresh reset
      RESET_N    = 1'b0;
      PLL_LOCKED = 1'b0;
      step(); step();
      check("glitch_pre_cnt", 32'(LOCK_LOSS_CNT), 0);
      RESET_N    = 1'b1;
      PLL_LOCKED = 1'b1;
      for (int i = 1; i <= 21; i++) begin
         step();
         if (i == 5) PLL_LOCKED = 1'b0;
         if (i == 6) PLL_LOCKED = 1'b1;
         if (i == 10) check("glitch_sys_nominal", 32'(RST_SYS_N), 0);
         if (i == 15) check("glitch_sys_early", 32'(RST_SYS_N), 0);
         if (i == 16) begin
            check("glitch_sys_rel", 32'(RST_SYS_N), 1);
            check("glitch_cnt", 32'(LOCK_LOSS_CNT), 0);
            check("glitch_state", 32'(dbg_state), 1);
         end
         if (i == 20) check("glitch_core_rel", 32'(RST_CORE_N), 1);
      end

      // Asynchronous RESET_N pulse while in REL_CORE
      check("arst_pre_state", 32'(dbg_state), 2);
      RESET_N = 1'b0;
      #1;
      check("arst_sys", 32'(RST_SYS_N), 0);
      check("arst_core", 32'(RST_CORE_N), 0);
      check("arst_video", 32'(RST_VIDEO_N), 0);
      check("arst_ready", 32'(READY), 0);
      check("arst_state", 32'(dbg_state), 0);
      step();
      RESET_N = 1'b1;
      bringup("arst_restart");

      // Saturation over 300 lock-loss events
      for (int n = 1; n <= 300; n++) begin
         PLL_LOCKED = 1'b0;
         step();
         PLL_LOCKED = 1'b1;
         t = 0;
         while (RST_SYS_N && t < 10) begin step(); t++; end
         if (RST_SYS_N) begin
            check("sat_drop_timeout", 32'(RST_SYS_N), 0);
            break;
         end
         t = 0;
         while (!RST_SYS_N && t < 30) begin step(); t++; end
         if (!RST_SYS_N) begin
            check("sat_relock_timeout", 32'(RST_SYS_N), 1);
            break;
         end
         if (n == 100) check("sat_cnt_100", 32'(LOCK_LOSS_CNT), 100);
         if (n == 254) check("sat_cnt_254", 32'(LOCK_LOSS_CNT), 254);
      end
      check("sat_cnt_final", 32'(LOCK_LOSS_CNT), 255);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
